// File: rtl/regs_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   state_t    : sweep/run FSM encoding used by regs_mp
//   DEF_*      : default parameter values for regs_mp and regs_mp_rdport
package regs_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

endpackage

// File: rtl/regs_mp_rdport.sv
// One registered read lane of the register file.
//   clk    : clock, rising edge
//   flush  : forces the lane output to zero (reset or clear sweep in progress)
//   raddr  : read address for this lane
//   entry  : current storage contents at raddr (combinational from the array)
//   wen    : qualified write enable of the file this cycle
//   waddr  : write address
//   wdata  : write data
//   rdata  : registered read data, one cycle after raddr is presented
module regs_mp_rdport
    import regs_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] entry,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic zero_hit;
    logic fwd_hit;

    // wen is already suppressed for address 0 when it is hardwired, so the
    // forward path can never deliver data for entry 0 in that configuration.
    assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
    assign fwd_hit  = (BYPASS != 0) && wen && (waddr == raddr);

    // Output register: read data leaves here one cycle after the address
    always_ff @(posedge clk) begin
        if (flush)
            rdata <= '0;
        else if (zero_hit)
            rdata <= '0;
        else if (fwd_hit)
            rdata <= wdata;
        else
            rdata <= entry;
    end

endmodule

// File: rtl/regs_mp.sv
// Multi-read-port register file with a post-reset clearing sweep.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset; restarts the clearing sweep
//   raddr_i : NUM_RD packed read addresses, lane k at [k*ADDR_W +: ADDR_W]
//   rdata_o : NUM_RD packed registered read data, lane k at [k*DATA_W +: DATA_W]
//   write_i : write request (ignored until ready_o)
//   waddr_i : write address
//   wdata_i : write data
//   ready_o : high once every entry has been cleared after reset
module regs_mp
    import regs_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic                     write_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic                     ready_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_idx, clr_idx_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              wen;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == ADDR_W'(DEPTH - 1))
                    state_next = RUN;
            end
            RUN: begin
                clr_idx_next = '0;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign ready_o = (state == RUN);
    assign run     = (state == RUN) && !rst_i;
    assign wen     = run && write_i && !((ZERO_REG != 0) && (waddr_i == '0));

    // Test backdoor: the task flips bd_seq; the storage process notices the
    // change and performs the write at the next edge, so the array keeps a
    // single writing process.
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;
    logic              bd_seq  = 1'b0;
    logic              bd_seen = 1'b0;

    task backdoor_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bd_addr = addr;
        bd_data = data;
        bd_seq  = ~bd_seq;
    endtask

    always_ff @(posedge clk_i) begin
        if (!rst_i && state == CLEAR)
            mem[clr_idx] <= '0;
        else if (wen)
            mem[waddr_i] <= wdata_i;
        if (bd_seq != bd_seen)
            mem[bd_addr] <= bd_data;
        bd_seen <= bd_seq;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        assign raddr = raddr_i[k*ADDR_W +: ADDR_W];

        regs_mp_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .clk  (clk_i),
            .flush(!run),
            .raddr(raddr),
            .entry(mem[raddr]),
            .wen  (wen),
            .waddr(waddr_i),
            .wdata(wdata_i),
            .rdata(rdata_o[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regs_mp.sv
// Scoreboard bench for regs_mp: two instances share all inputs,
// dut0 with ZERO_REG=1/BYPASS=1 and dut1 with ZERO_REG=0/BYPASS=0.
module tb_regs_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i   = 1'b1;
    logic              write_i = 1'b0;
    logic [AW-1:0]     waddr_i = '0;
    logic [DW-1:0]     wdata_i = '0;
    logic [NR*AW-1:0]  raddr_i = '0;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic              ready0, ready1;

    regs_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata0),
        .write_i(write_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .ready_o(ready0));

    regs_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata1),
        .write_i(write_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .ready_o(ready1));

    typedef struct {
        int          due;
        int          inst;
        int          lane;
        logic [DW-1:0] exp;
        string       name;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [DW-1:0] m0[DEPTH];
    logic [DW-1:0] m1[DEPTH];
    int          sweep  = 0;
    bit          known  = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation in the cycle it falls due
    initial begin
        item_t it;
        logic [DW-1:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it  = sb.pop_front();
                act = (it.inst == 0) ? rdata0[it.lane*DW +: DW] : rdata1[it.lane*DW +: DW];
                check($sformatf("%s dut%0d lane%0d", it.name, it.inst, it.lane), act, it.exp);
            end
        end
    end

    // One clock of stimulus; expectations come from the reference arrays.
    task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra0,
                        input logic [AW-1:0] ra1, input string tag);
        logic [AW-1:0] ra[NR];
        logic [DW-1:0] e0, e1;
        item_t it;
        if (known) begin
            check({tag, " ready dut0"}, DW'(ready0), DW'(sweep >= DEPTH));
            check({tag, " ready dut1"}, DW'(ready1), DW'(sweep >= DEPTH));
        end
        ra[0] = ra0;
        ra[1] = ra1;
        rst_i   = rst;
        write_i = we;
        waddr_i = wa;
        wdata_i = wd;
        raddr_i = {ra1, ra0};
        if (rst || known) begin
            for (int k = 0; k < NR; k++) begin
                if (rst || sweep < DEPTH) begin
                    e0 = '0;
                    e1 = '0;
                end else begin
                    if (ra[k] == 0)
                        e0 = '0;
                    else if (we && wa == ra[k])
                        e0 = wd;
                    else
                        e0 = m0[ra[k]];
                    e1 = m1[ra[k]];
                end
                it.due = cyc + 1; it.lane = k; it.name = tag;
                it.inst = 0; it.exp = e0; sb.push_back(it);
                it.inst = 1; it.exp = e1; sb.push_back(it);
            end
        end
        if (rst) begin
            sweep = 0;
            known = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
        end else if (sweep < DEPTH) begin
            sweep++;
        end else if (we) begin
            if (wa != 0) m0[wa] = wd;
            m1[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input string tag);
        step(1'b0, 1'b0, '0, '0, ra0, ra1, tag);
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] v);
        dut0.backdoor_write(a, v);
        dut1.backdoor_write(a, v);
        if (known && sweep >= DEPTH) begin
            if (a != 0) m0[a] = v;
            m1[a] = v;
        end
    endtask

    // Runs the full sweep after reset, counting cycles with ready low
    task automatic sweep_run(input string tag);
        int lows = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready0 == 1'b0) lows++;
            if (i == 1)
                step(1'b0, 1'b1, AW'(3), 32'h12345678, AW'(3), AW'(i), tag);
            else
                step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, AW'($urandom), AW'($urandom), tag);
        end
        check({tag, " ready low cycles"}, DW'(lows), DW'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, '0, '0, '0, '0, "reset");
        sweep_run("sweep");

        for (int i = 0; i < DEPTH; i += 2)
            idle(AW'(i), AW'(i + 1), "post-sweep zero");

        step(1'b0, 1'b1, AW'(7), 32'hDEADBEEF, AW'(1), AW'(2), "wr7");
        idle(AW'(7), AW'(7), "rd7");

        step(1'b0, 1'b1, AW'(5), 32'h11111111, AW'(9), AW'(9), "wr5");
        step(1'b0, 1'b1, AW'(5), 32'h22222222, AW'(9), AW'(5), "bypass5");
        idle(AW'(5), AW'(5), "rd5");

        step(1'b0, 1'b1, AW'(0), 32'hFFFFFFFF, AW'(0), AW'(0), "zero wr");
        idle(AW'(0), AW'(0), "zero rd");
        idle(AW'(3), AW'(0), "clear-write rd3");

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            step(1'b0, 1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 1) == 1) ? a : AW'($urandom), AW'($urandom_range(0, 3)), "random");
        end

        backdoor(AW'(20), 32'hA5A5A5A5);
        idle(AW'(1), AW'(2), "bd settle");
        idle(AW'(20), AW'(20), "bd rd20");

        step(1'b1, 1'b1, AW'(9), 32'h0BADF00D, AW'(20), AW'(9), "reset run");
        for (int i = 0; i < 10; i++) idle(AW'(20), AW'(i), "partial sweep");
        backdoor(AW'(20), 32'hA5A5A5A5);
        idle(AW'(20), AW'(20), "sweep10");
        step(1'b1, 1'b0, '0, '0, '0, '0, "mid reset");
        sweep_run("resweep");
        idle(AW'(20), AW'(9), "rd20 after resweep");
        idle(AW'(3), AW'(7), "rd after resweep");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regs_mp.md
REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The module SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 The module SHALL have parameter ZERO_REG, default 1, meaning entry 0 hardwired to zero when 1.
REQ-005 The module SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding enabled when 1.
REQ-006 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port raddr_i, input, NUM_RD*ADDR_W bits: read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 The module SHALL have port rdata_o, output, NUM_RD*DATA_W bits: registered read data, port k at bits [k*DATA_W +: DATA_W].
REQ-010 The module SHALL have port write_i, input, 1 bit: write request.
REQ-011 The module SHALL have port waddr_i, input, ADDR_W bits: write address.
REQ-012 The module SHALL have port wdata_i, input, DATA_W bits: write data.
REQ-013 The module SHALL have port ready_o, output, 1 bit: high when the initialisation sweep is complete and the file accepts accesses.

Function
REQ-014 The block SHALL have a 2-state FSM, CLEAR and RUN.
REQ-015 In CLEAR, the block SHALL write zero to entry clr_idx each cycle, with clr_idx running 0..DEPTH-1.
REQ-016 The FSM SHALL go to RUN on the cycle after entry DEPTH-1 is cleared, so ready_o rises exactly DEPTH cycles after rst_i deasserts.
REQ-017 In CLEAR, the block SHALL ignore write_i, hold ready_o=0, and drive every rdata_o lane to 0.
REQ-018 In RUN, read latency SHALL be 1 cycle: rdata_o lane k at cycle t+1 = entry raddr_i[k] sampled at cycle t.
REQ-019 In RUN, when write_i=1 the block SHALL store wdata_i into waddr_i at the clock edge, with the new value visible to reads issued from the next cycle on.
REQ-020 With BYPASS=1, when write_i=1 and waddr_i equals raddr_i[k] in the same cycle, lane k SHALL return wdata_i at t+1.
REQ-021 With BYPASS=0, in the same same-cycle write/read case, lane k SHALL return the pre-write value at t+1.
REQ-022 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and the bypass rule SHALL NOT apply to address 0.
REQ-023 With ZERO_REG=0, entry 0 SHALL behave as an ordinary entry.
REQ-024 Multiple read ports addressing the same entry SHALL each return identical data.
REQ-025 Read lanes SHALL be independent; one port's address SHALL NOT affect another lane's data.
REQ-026 Contents SHALL be retained indefinitely while write_i=0.
REQ-027 No write or read SHALL alter any entry other than waddr_i.

Reset
REQ-028 While rst_i=1, the FSM SHALL be forced to CLEAR with clr_idx=0, ready_o=0 and all rdata_o lanes 0.
REQ-029 Asserting rst_i mid-sweep or in RUN SHALL restart the sweep from entry 0 on the next cycle after deassertion.
REQ-030 Entry contents SHALL NOT be required to change during rst_i=1; the sweep after deassertion SHALL zero them.
REQ-031 When built under the Verilator define, a DPI-exported backdoor task SHALL set any entry value directly for tests.

Structure
REQ-032 Package regs_mp_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default parameter constants.
REQ-033 One sub-module, regs_mp_rdport, SHALL be instantiated NUM_RD times via generate; it holds the output register, zero-address mask and bypass compare for one lane.
REQ-034 The storage array and clear FSM SHALL live in regs_mp.

Verification
REQ-035 Reset: rst_i high 3 cycles, then low, with ADDR_W=5 -> ready_o=0 for exactly 32 cycles then 1; all 32 entries read 0.
REQ-036 Write/read: write 0xDEADBEEF to entry 7, then read port 0 at address 7 on the next cycle -> rdata_o lane 0 = 0xDEADBEEF one cycle later.
REQ-037 Bypass: entry 5 = 0x11111111; same cycle write 0x22222222 to entry 5 and read entry 5 on port 1 -> lane 1 = 0x22222222 with BYPASS=1, 0x11111111 with BYPASS=0.
REQ-038 Zero register: write 0xFFFFFFFF to address 0 while reading address 0 -> lane reads 0 at t+1 and afterwards (ZERO_REG=1).
REQ-039 Mid-sweep reset: pulse rst_i at sweep cycle 10, after backdoor writing entry 20 = 0xA5A5A5A5 -> ready_o low 32 more cycles; entry 20 reads 0.
REQ-040 Write during CLEAR: write 0x12345678 to entry 3 at sweep cycle 1 -> entry 3 reads 0 after ready_o rises.
